// File: rtl/t5_pkg.sv
// Shared definitions for the t5_rv32i load/store unit.
// Contents: funct3 access-size encodings, LSU state encoding, and the
// request legality check (size/sign vs. direction, natural alignment).
package t5_pkg;

    localparam logic [2:0] LSU_FN_B  = 3'b000;
    localparam logic [2:0] LSU_FN_H  = 3'b001;
    localparam logic [2:0] LSU_FN_W  = 3'b010;
    localparam logic [2:0] LSU_FN_BU = 3'b100;
    localparam logic [2:0] LSU_FN_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'b00,
        LSU_BUS   = 2'b01,
        LSU_DONE  = 2'b10,
        LSU_FAULT = 2'b11
    } lsu_state_e;

    // Unsigned variants only exist for loads; H and W need natural alignment.
    function automatic logic lsu_legal(input logic wre, input logic [2:0] fn,
                                       input logic [1:0] adr_lo);
        logic ok;
        case (fn)
            LSU_FN_B:  ok = 1'b1;
            LSU_FN_H:  ok = ~adr_lo[0];
            LSU_FN_W:  ok = (adr_lo == 2'b00);
            LSU_FN_BU: ok = ~wre;
            LSU_FN_HU: ok = ~wre & ~adr_lo[0];
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/t5_lsu_align.sv
// Combinational lane logic for the load/store unit.
// Store side: byte-lane select and lane-replicated write data from
//   (st_fn, st_adr_lo, st_wdat) -> st_sel, st_dto.
// Load side: shifts the bus word down by the byte offset and sign- or
//   zero-extends per ld_fn -> ld_rdat.
module t5_lsu_align
    import t5_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      st_fn,
    input  logic [1:0]      st_adr_lo,
    input  logic [XLEN-1:0] st_wdat,
    output logic [3:0]      st_sel,
    output logic [XLEN-1:0] st_dto,
    input  logic [2:0]      ld_fn,
    input  logic [1:0]      ld_adr_lo,
    input  logic [XLEN-1:0] ld_dti,
    output logic [XLEN-1:0] ld_rdat
);

    logic [XLEN-1:0] shifted_s;

    // Store lanes: replicate the right-justified datum across every lane so
    // the responder finds it in whichever lane sel enables.
    always_comb begin
        st_sel = 4'b0000;
        st_dto = st_wdat;
        case (st_fn[1:0])
            2'b00: begin
                st_sel = 4'b0001 << st_adr_lo;
                st_dto = {4{st_wdat[7:0]}};
            end
            2'b01: begin
                st_sel = st_adr_lo[1] ? 4'b1100 : 4'b0011;
                st_dto = {2{st_wdat[15:0]}};
            end
            default: begin
                st_sel = 4'b1111;
                st_dto = st_wdat;
            end
        endcase
    end

    // Load extraction: right-justify the addressed bytes, then extend.
    always_comb begin
        shifted_s = ld_dti >> {ld_adr_lo, 3'b000};
        ld_rdat   = {XLEN{1'b0}};
        case (ld_fn)
            LSU_FN_B:  ld_rdat = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
            LSU_FN_BU: ld_rdat = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
            LSU_FN_H:  ld_rdat = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            LSU_FN_HU: ld_rdat = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
            LSU_FN_W:  ld_rdat = shifted_s;
            default:   ld_rdat = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/t5_lsu.sv
// t5_rv32i load/store unit: data-bus (dwb_*) initiator.
// Pipeline side: lsu_req/lsu_wre/lsu_fn/lsu_adr/lsu_wdat in; lsu_busy,
//   lsu_done (1-cycle pulse), lsu_err (illegal/misaligned), lsu_rdat out.
// Bus side: registered dwb_adr/dwb_dto/dwb_sel/dwb_stb/dwb_wre out;
//   dwb_ack/dwb_dti in. One bus cycle per request, stb drops after ack.
module t5_lsu
    import t5_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            sys_ena,
    input  logic            lsu_req,
    input  logic            lsu_wre,
    input  logic [2:0]      lsu_fn,
    input  logic [31:0]     lsu_adr,
    input  logic [XLEN-1:0] lsu_wdat,
    output logic            lsu_busy,
    output logic            lsu_done,
    output logic            lsu_err,
    output logic [XLEN-1:0] lsu_rdat,
    output logic [29:0]     dwb_adr,
    output logic [31:0]     dwb_dto,
    output logic [3:0]      dwb_sel,
    output logic            dwb_stb,
    output logic            dwb_wre,
    input  logic            dwb_ack,
    input  logic [XLEN-1:0] dwb_dti
);

    lsu_state_e      state_r;
    lsu_state_e      state_nxt_s;
    logic [2:0]      ld_fn_r;
    logic [1:0]      ld_adr_lo_r;
    logic            legal_s;
    logic [3:0]      sel_s;
    logic [XLEN-1:0] dto_s;
    logic [XLEN-1:0] rdat_s;

    assign legal_s = lsu_legal(lsu_wre, lsu_fn, lsu_adr[1:0]);

    t5_lsu_align #(.XLEN(XLEN)) u_align (
        .st_fn     (lsu_fn),
        .st_adr_lo (lsu_adr[1:0]),
        .st_wdat   (lsu_wdat),
        .st_sel    (sel_s),
        .st_dto    (dto_s),
        .ld_fn     (ld_fn_r),
        .ld_adr_lo (ld_adr_lo_r),
        .ld_dti    (dwb_dti),
        .ld_rdat   (rdat_s)
    );

    // Next-state: requests are only taken in IDLE; ack only matters in BUS.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LSU_IDLE: begin
                if (lsu_req && sys_ena) begin
                    state_nxt_s = legal_s ? LSU_BUS : LSU_FAULT;
                end else begin
                    state_nxt_s = LSU_IDLE;
                end
            end
            LSU_BUS: begin
                if (dwb_ack) begin
                    state_nxt_s = LSU_DONE;
                end else begin
                    state_nxt_s = LSU_BUS;
                end
            end
            LSU_DONE:  state_nxt_s = LSU_IDLE;
            LSU_FAULT: state_nxt_s = LSU_IDLE;
            default:   state_nxt_s = LSU_IDLE;
        endcase
    end

    // State and all outputs registered; status flags follow the next state so
    // they line up with the state they describe.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r     <= LSU_IDLE;
            lsu_busy    <= 1'b0;
            lsu_done    <= 1'b0;
            lsu_err     <= 1'b0;
            lsu_rdat    <= {XLEN{1'b0}};
            dwb_adr     <= 30'd0;
            dwb_dto     <= 32'd0;
            dwb_sel     <= 4'd0;
            dwb_stb     <= 1'b0;
            dwb_wre     <= 1'b0;
            ld_fn_r     <= 3'd0;
            ld_adr_lo_r <= 2'd0;
        end else begin
            state_r  <= state_nxt_s;
            lsu_busy <= (state_nxt_s != LSU_IDLE);
            lsu_done <= (state_nxt_s == LSU_DONE) || (state_nxt_s == LSU_FAULT);
            lsu_err  <= (state_nxt_s == LSU_FAULT);
            if ((state_r == LSU_IDLE) && (state_nxt_s == LSU_BUS)) begin
                dwb_stb     <= 1'b1;
                dwb_wre     <= lsu_wre;
                dwb_adr     <= lsu_adr[31:2];
                dwb_sel     <= sel_s;
                dwb_dto     <= dto_s;
                ld_fn_r     <= lsu_fn;
                ld_adr_lo_r <= lsu_adr[1:0];
            end else if ((state_r == LSU_BUS) && dwb_ack) begin
                // Capture before the responder may drop dti; stores report zero.
                dwb_stb  <= 1'b0;
                dwb_wre  <= 1'b0;
                lsu_rdat <= dwb_wre ? {XLEN{1'b0}} : rdat_s;
            end
        end
    end

endmodule

// File: tb/tb_t5_lsu.sv
module tb_t5_lsu;
    import t5_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        sys_ena = 1'b0;
    logic        lsu_req = 1'b0;
    logic        lsu_wre = 1'b0;
    logic [2:0]  lsu_fn = 3'd0;
    logic [31:0] lsu_adr = 32'd0;
    logic [31:0] lsu_wdat = 32'd0;
    logic        lsu_busy, lsu_done, lsu_err;
    logic [31:0] lsu_rdat;
    logic [29:0] dwb_adr;
    logic [31:0] dwb_dto;
    logic [3:0]  dwb_sel;
    logic        dwb_stb, dwb_wre;
    logic        resp_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [31:0] dwb_dti = 32'd0;

    int tests = 0;
    int fails = 0;
    int ack_dly = 0;

    typedef struct { logic err; logic [31:0] rdat; } done_exp_t;
    typedef struct { logic wre; logic [29:0] adr; logic [3:0] sel; logic [31:0] dto; } bus_exp_t;
    done_exp_t done_q[$];
    bus_exp_t  bus_q[$];
    logic [7:0] resp_mem[64];
    logic [7:0] model_mem[64];

    always #5 sys_clk = ~sys_clk;

    t5_lsu #(.XLEN(32)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_ena(sys_ena),
        .lsu_req(lsu_req), .lsu_wre(lsu_wre), .lsu_fn(lsu_fn),
        .lsu_adr(lsu_adr), .lsu_wdat(lsu_wdat),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err),
        .lsu_rdat(lsu_rdat),
        .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel),
        .dwb_stb(dwb_stb), .dwb_wre(dwb_wre),
        .dwb_ack(resp_ack | spur_ack), .dwb_dti(dwb_dti)
    );

    // Responder: acks ack_dly cycles after seeing stb, backed by resp_mem.
    initial begin
        int w;
        forever begin
            @(posedge sys_clk); #1;
            if (dwb_stb === 1'b1 && !sys_rst) begin
                for (int k = 0; k < ack_dly; k++) begin
                    @(posedge sys_clk); #1;
                end
                if (dwb_stb === 1'b1 && !sys_rst) begin
                    w = int'(dwb_adr[3:0]);
                    if (dwb_wre) begin
                        for (int l = 0; l < 4; l++)
                            if (dwb_sel[l]) resp_mem[4*w+l] = dwb_dto[8*l +: 8];
                    end else begin
                        dwb_dti = {resp_mem[4*w+3], resp_mem[4*w+2], resp_mem[4*w+1], resp_mem[4*w]};
                    end
                    resp_ack = 1'b1;
                    @(posedge sys_clk); #1;
                    resp_ack = 1'b0;
                    dwb_dti  = 32'd0;
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every lsu_done.
    initial begin
        done_exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                prev = 1'b0;
            end else begin
                if (lsu_done === 1'b1) begin
                    tests++;
                    if (prev) begin
                        fails++;
                        $display("FAIL done_pulse: done high 2 cycles, required 1");
                    end
                    tests++;
                    if (done_q.size() == 0) begin
                        fails++;
                        $display("FAIL done_unexpected: done=1 err=%0b, required no completion", lsu_err);
                    end else begin
                        e = done_q.pop_front();
                        if (lsu_err !== e.err || (!e.err && lsu_rdat !== e.rdat)) begin
                            fails++;
                            $display("FAIL done_resp: err=%0b rdat=%08h, required err=%0b rdat=%08h",
                                     lsu_err, lsu_rdat, e.err, e.rdat);
                        end
                    end
                end
                prev = lsu_done;
            end
        end
    end

    // Bus monitor: checks fields at stb rise and stability while stb stays high.
    initial begin
        bus_exp_t e, cap;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                prev = 1'b0;
            end else begin
                if (dwb_stb === 1'b1 && !prev) begin
                    tests++;
                    cap.wre = dwb_wre; cap.adr = dwb_adr; cap.sel = dwb_sel; cap.dto = dwb_dto;
                    if (bus_q.size() == 0) begin
                        fails++;
                        $display("FAIL bus_unexpected: stb=1 adr=%08h, required stb=0", dwb_adr);
                    end else begin
                        e = bus_q.pop_front();
                        if (dwb_wre !== e.wre || dwb_adr !== e.adr || dwb_sel !== e.sel ||
                            (e.wre && dwb_dto !== e.dto)) begin
                            fails++;
                            $display("FAIL bus_fields: wre=%0b adr=%08h sel=%h dto=%08h, required wre=%0b adr=%08h sel=%h dto=%08h",
                                     dwb_wre, dwb_adr, dwb_sel, dwb_dto, e.wre, e.adr, e.sel, e.dto);
                        end
                    end
                end else if (dwb_stb === 1'b1) begin
                    tests++;
                    if (dwb_wre !== cap.wre || dwb_adr !== cap.adr || dwb_sel !== cap.sel || dwb_dto !== cap.dto) begin
                        fails++;
                        $display("FAIL bus_stable: adr=%08h sel=%h dto=%08h, required adr=%08h sel=%h dto=%08h",
                                 dwb_adr, dwb_sel, dwb_dto, cap.adr, cap.sel, cap.dto);
                    end
                end
                prev = dwb_stb;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_op(input logic wre, input logic [2:0] fn, input logic [31:0] adr,
                         input logic [31:0] wdat, input int dly, input logic exp_err,
                         input logic [31:0] exp_rdat, input logic [3:0] exp_sel,
                         input logic [31:0] exp_dto);
        done_exp_t d;
        bus_exp_t  b;
        int cyc;
        int want;
        ack_dly = dly;
        d.err = exp_err; d.rdat = exp_rdat;
        done_q.push_back(d);
        if (!exp_err) begin
            b.wre = wre; b.adr = adr[31:2]; b.sel = exp_sel; b.dto = exp_dto;
            bus_q.push_back(b);
        end
        lsu_wre = wre; lsu_fn = fn; lsu_adr = adr; lsu_wdat = wdat; lsu_req = 1'b1;
        @(posedge sys_clk); #1;
        lsu_req = 1'b0;
        cyc = 1;
        while (lsu_done !== 1'b1 && cyc < 60) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        want = exp_err ? 1 : dly + 2;
        tests++;
        if (lsu_done !== 1'b1) begin
            fails++;
            $display("FAIL op_timeout: no done in %0d cycles, required done", cyc);
        end else if (cyc != want) begin
            fails++;
            $display("FAIL op_latency: %0d cycles, required %0d", cyc, want);
        end
        @(posedge sys_clk); #1;
        tests++;
        if (lsu_busy !== 1'b0 || lsu_done !== 1'b0) begin
            fails++;
            $display("FAIL op_idle: busy=%0b done=%0b, required 0/0", lsu_busy, lsu_done);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        for (int i = 0; i < 4; i++) resp_mem[4*idx+i] = val[8*i +: 8];
    endtask

    // Byte-wise reference model for the mixed-op run.
    task automatic model_op();
        logic wre, legal;
        logic [2:0] fn;
        logic [31:0] adr, wdat, v, dto;
        logic [3:0] sel;
        int n, o, a, pick;
        pick = $urandom_range(0, 11);
        wre  = 1'($urandom_range(0, 1));
        case (pick)
            0, 1, 2:  fn = 3'b000;
            3, 4:     fn = 3'b001;
            5, 6, 7:  fn = 3'b010;
            8:        fn = 3'b100;
            9, 10:    fn = 3'b101;
            default:  fn = 3'b011;
        endcase
        adr  = 32'h100 + 32'($urandom_range(0, 63));
        wdat = $urandom;
        n = (fn[1:0] == 2'b00) ? 1 : (fn[1:0] == 2'b01) ? 2 : 4;
        o = int'(adr[1:0]);
        a = int'(adr - 32'h100);
        legal = (wre ? (fn <= 3'b010) : (fn inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                && ((o % n) == 0);
        sel = 4'((1 << n) - 1);
        sel = sel << o;
        for (int i = 0; i < 4; i++) dto[8*i +: 8] = wdat[8*(i % n) +: 8];
        v = 32'd0;
        if (legal && wre) begin
            for (int i = 0; i < n; i++) model_mem[a+i] = wdat[8*i +: 8];
        end else if (legal) begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[a+i];
            if (!fn[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        end
        do_op(wre, fn, adr, wdat, $urandom_range(0, 7), !legal, v, sel, dto);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin resp_mem[i] = 8'h00; model_mem[i] = 8'h00; end
        repeat (3) @(posedge sys_clk);
        #1;
        tests++;
        if (dwb_stb !== 1'b0 || dwb_wre !== 1'b0 || lsu_busy !== 1'b0 || lsu_done !== 1'b0 ||
            lsu_err !== 1'b0 || dwb_adr !== 30'd0 || dwb_dto !== 32'd0 || dwb_sel !== 4'd0 ||
            lsu_rdat !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: stb=%0b busy=%0b done=%0b adr=%08h sel=%h dto=%08h rdat=%08h, required all 0",
                     dwb_stb, lsu_busy, lsu_done, dwb_adr, dwb_sel, dwb_dto, lsu_rdat);
        end
        sys_rst = 1'b0;
        sys_ena = 1'b1;
        @(posedge sys_clk); #1;

        // Directed vectors with hand-computed expectations.
        do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF);
        do_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 1'b0, 32'h0, 4'h8, 32'hA5A5A5A5);
        do_op(1'b1, 3'b001, 32'h102, 32'h00001234, 3, 1'b0, 32'h0, 4'hC, 32'h12341234);
        set_word(0, 32'h0000_8000);
        do_op(1'b0, 3'b000, 32'h101, 32'h0, 0, 1'b0, 32'hFFFFFF80, 4'h2, 32'h0);
        do_op(1'b0, 3'b100, 32'h101, 32'h0, 2, 1'b0, 32'h00000080, 4'h2, 32'h0);
        set_word(0, 32'h8001_0000);
        do_op(1'b0, 3'b001, 32'h102, 32'h0, 0, 1'b0, 32'hFFFF8001, 4'hC, 32'h0);
        do_op(1'b0, 3'b101, 32'h102, 32'h0, 5, 1'b0, 32'h00008001, 4'hC, 32'h0);
        do_op(1'b0, 3'b010, 32'h102, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0);
        do_op(1'b0, 3'b001, 32'h101, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0);
        do_op(1'b0, 3'b011, 32'h100, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0);
        do_op(1'b1, 3'b100, 32'h100, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0);

        // sys_ena low blocks a pending request.
        sys_ena = 1'b0;
        lsu_wre = 1'b0; lsu_fn = 3'b010; lsu_adr = 32'h104; lsu_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge sys_clk); #1;
            tests++;
            if (dwb_stb !== 1'b0 || lsu_busy !== 1'b0) begin
                fails++;
                $display("FAIL ena_block: stb=%0b busy=%0b, required 0/0", dwb_stb, lsu_busy);
            end
        end
        lsu_req = 1'b0;
        sys_ena = 1'b1;

        // Ack while idle must be ignored.
        spur_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk); #1;
            tests++;
            if (lsu_busy !== 1'b0 || lsu_done !== 1'b0) begin
                fails++;
                $display("FAIL idle_ack: busy=%0b done=%0b, required 0/0", lsu_busy, lsu_done);
            end
        end
        spur_ack = 1'b0;

        // Reset while a bus cycle waits for ack.
        begin
            bus_exp_t b;
            b.wre = 1'b0; b.adr = 30'h41; b.sel = 4'hF; b.dto = 32'h0;
            bus_q.push_back(b);
            ack_dly = 20;
            lsu_wre = 1'b0; lsu_fn = 3'b010; lsu_adr = 32'h104; lsu_req = 1'b1;
            @(posedge sys_clk); #1;
            lsu_req = 1'b0;
            @(posedge sys_clk); #1;
            tests++;
            if (dwb_stb !== 1'b1 || lsu_busy !== 1'b1) begin
                fails++;
                $display("FAIL rst_pre: stb=%0b busy=%0b, required 1/1", dwb_stb, lsu_busy);
            end
            sys_rst = 1'b1;
            #1;
            tests++;
            if (dwb_stb !== 1'b0 || lsu_busy !== 1'b0 || lsu_done !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid: stb=%0b busy=%0b done=%0b, required 0/0/0",
                         dwb_stb, lsu_busy, lsu_done);
            end
            @(posedge sys_clk); #1;
            sys_rst = 1'b0;
            repeat (25) @(posedge sys_clk);
            #1;
        end
        set_word(1, 32'hCAFE_F00D);
        do_op(1'b0, 3'b010, 32'h104, 32'h0, 1, 1'b0, 32'hCAFEF00D, 4'hF, 32'h0);

        // Mixed ops against the byte model.
        for (int i = 0; i < 64; i++) begin resp_mem[i] = 8'h00; model_mem[i] = 8'h00; end
        for (int i = 0; i < 1000; i++) model_op();

        tests++;
        if (done_q.size() != 0 || bus_q.size() != 0) begin
            fails++;
            $display("FAIL queues_drained: done_q=%0d bus_q=%0d, required 0/0", done_q.size(), bus_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
